// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one host command in, one response out.
// Runs AW/W/B or AR/R handshakes and keeps saturating per-type counters.
module axi4_lite_master #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int STRB_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awprot,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arprot,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE, WR, WB, RA, RD, RSP
  } state_t;

  state_t state_q, state_d;

  logic              aw_q, w_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rdat_q;
  logic [STRB_W-1:0] strb_q;
  logic [1:0]        resp_q;
  logic [CNT_W-1:0]  wr_q_cnt, rd_q_cnt, err_q_cnt;

  logic cmd_hs, aw_hs, w_hs, b_hs, r_hs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign cmd_hs = (state_q == IDLE) && cmd_valid;
  assign aw_hs  = aw_q && awready;
  assign w_hs   = w_q && wready;
  assign b_hs   = (state_q == WB) && bvalid;
  assign r_hs   = (state_q == RD) && rvalid;

  // Handshake-side controls decode straight from the state register.
  assign cmd_ready = (state_q == IDLE);
  assign bready    = (state_q == WB);
  assign arvalid   = (state_q == RA);
  assign rready    = (state_q == RD);
  assign rsp_valid = (state_q == RSP);

  assign awvalid = aw_q;
  assign wvalid  = w_q;
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = data_q;
  assign wstrb   = strb_q;
  assign awprot  = 1'b0;
  assign arprot  = 1'b0;

  assign rsp_write = wr_q;
  assign rsp_rdata = rdat_q;
  assign rsp_resp  = resp_q;
  assign wr_cnt    = wr_q_cnt;
  assign rd_cnt    = rd_q_cnt;
  assign err_cnt   = err_q_cnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid) state_d = cmd_write ? WR : RA;
      WR: begin
        // AW and W may finish in either order or together.
        if ((!aw_q || awready) && (!w_q || wready))
          state_d = WB;
      end
      WB:  if (bvalid)    state_d = RSP;
      RA:  if (arready)   state_d = RD;
      RD:  if (rvalid)    state_d = RSP;
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_q      <= 1'b0;
      w_q       <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      rdat_q    <= '0;
      resp_q    <= '0;
      wr_q_cnt  <= '0;
      rd_q_cnt  <= '0;
      err_q_cnt <= '0;
    end else begin
      if (cmd_hs) begin
        addr_q <= cmd_addr;
        data_q <= cmd_wdata;
        strb_q <= cmd_wstrb;
        aw_q   <= cmd_write;
        w_q    <= cmd_write;
      end else begin
        if (aw_hs) aw_q <= 1'b0;
        if (w_hs)  w_q  <= 1'b0;
      end
      if (b_hs) begin
        wr_q     <= 1'b1;
        rdat_q   <= '0;
        resp_q   <= bresp;
        wr_q_cnt <= sat_inc(wr_q_cnt);
        if (bresp != 2'b00) err_q_cnt <= sat_inc(err_q_cnt);
      end
      if (r_hs) begin
        wr_q     <= 1'b0;
        rdat_q   <= rdata;
        resp_q   <= rresp;
        rd_q_cnt <= sat_inc(rd_q_cnt);
        if (rresp != 2'b00) err_q_cnt <= sat_inc(err_q_cnt);
      end
    end
  end

endmodule
